// File: rtl/debounce_pulse_if.sv
// Button conditioner bundle: raw input and tick in,
// debounced level and edge strobes out.
interface debounce_pulse_if;
  logic TICK;
  logic BTN_IN;
  logic LEVEL;
  logic PRESS;
  logic RELEASE;

  modport master (
    output TICK,
    output BTN_IN,
    input  LEVEL,
    input  PRESS,
    input  RELEASE
  );

  modport slave (
    input  TICK,
    input  BTN_IN,
    output LEVEL,
    output PRESS,
    output RELEASE
  );
endinterface

// File: rtl/debounce_pulse.sv
// Debouncer: synchronizer, 4-state stability FSM,
// registered level with one-cycle press/release strobes.
module debounce_pulse #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 4
) (
  input  logic             CLK,
  input  logic             RST,
  debounce_pulse_if.slave  bus
);

  typedef enum logic [1:0] {
    LOW,
    RISE_WAIT,
    HIGH,
    FALL_WAIT
  } state_e;

  localparam logic [CNT_W-1:0] CNT_TERM =
    CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   rel_q, rel_d;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q  <= '0;
      state_q <= LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.BTN_IN};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // A mismatch against the waited-for level wins over a tick
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      LOW: begin
        if (sync_out) begin
          state_d = RISE_WAIT;
          cnt_d   = '0;
        end
      end
      RISE_WAIT: begin
        if (!sync_out) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (bus.TICK && cnt_q == CNT_TERM) begin
          state_d = HIGH;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end else if (bus.TICK) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HIGH: begin
        if (!sync_out) begin
          state_d = FALL_WAIT;
          cnt_d   = '0;
        end
      end
      FALL_WAIT: begin
        if (sync_out) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (bus.TICK && cnt_q == CNT_TERM) begin
          state_d = LOW;
          level_d = 1'b0;
          rel_d   = 1'b1;
          cnt_d   = '0;
        end else if (bus.TICK) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.LEVEL   = level_q;
  assign bus.PRESS   = press_q;
  assign bus.RELEASE = rel_q;

endmodule

// File: tb/tb_debounce_pulse.sv
// Directed bench for debounce_pulse: reset, clean press,
// bounce, tick gating, release and reset mid-wait.
module tb_debounce_pulse;

  logic clk;
  logic rst;
  debounce_pulse_if bus ();

  debounce_pulse dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int edge_n;
  int press_n, rel_n;
  int press_at, rel_at;
  int both_n;
  int tick_per;

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, obs, exp);
    end
  endtask

  task automatic clr();
    edge_n   = 0;
    press_n  = 0;
    rel_n    = 0;
    press_at = -1;
    rel_at   = -1;
    both_n   = 0;
  endtask

  task automatic run_btn(input int n, input logic v);
    bus.BTN_IN = v;
    for (int i = 0; i < n; i++) begin
      edge_n++;
      bus.TICK = (tick_per == 1) ? 1'b1 :
                 ((edge_n % tick_per) == 0);
      @(posedge clk);
      #1;
      if (bus.PRESS) begin
        press_n++;
        if (press_at < 0) press_at = edge_n;
      end
      if (bus.RELEASE) begin
        rel_n++;
        if (rel_at < 0) rel_at = edge_n;
      end
      if (bus.PRESS && bus.RELEASE) both_n++;
    end
  endtask

  task automatic do_reset(input int n, input logic v);
    int bad;
    bad = 0;
    rst = 1'b1;
    bus.BTN_IN = v;
    bus.TICK = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.LEVEL || bus.PRESS || bus.RELEASE) bad++;
    end
    rst = 1'b0;
    chk("reset_outs_low", bad, 0);
  endtask

  int mark;

  initial begin
    checks   = 0;
    errors   = 0;
    tick_per = 1;
    rst      = 1'b1;
    bus.TICK = 1'b1;
    bus.BTN_IN = 1'b0;
    clr();

    // 1: input high through reset
    do_reset(3, 1'b1);
    chk("t1_level_after_rst", int'(bus.LEVEL), 0);
    clr();
    run_btn(40, 1'b1);
    chk("t1_press_edge", press_at, 19);
    chk("t1_press_cnt", press_n, 1);
    chk("t1_level", int'(bus.LEVEL), 1);

    // 2: clean press
    do_reset(2, 1'b0);
    clr();
    run_btn(5, 1'b0);
    clr();
    run_btn(40, 1'b1);
    chk("t2_press_edge", press_at, 19);
    chk("t2_press_cnt", press_n, 1);
    chk("t2_rel_cnt", rel_n, 0);
    chk("t2_level", int'(bus.LEVEL), 1);

    // 3: bounce
    do_reset(2, 1'b0);
    clr();
    run_btn(5, 1'b0);
    clr();
    run_btn(10, 1'b1);
    run_btn(3, 1'b0);
    run_btn(5, 1'b1);
    run_btn(2, 1'b0);
    chk("t3_no_early_press", press_n, 0);
    mark = edge_n;
    run_btn(40, 1'b1);
    chk("t3_press_edge", press_at, mark + 19);
    chk("t3_press_cnt", press_n, 1);
    chk("t3_rel_cnt", rel_n, 0);

    // 5: release from LEVEL=1
    clr();
    run_btn(40, 1'b0);
    chk("t5_rel_edge", rel_at, 19);
    chk("t5_rel_cnt", rel_n, 1);
    chk("t5_press_cnt", press_n, 0);
    chk("t5_level", int'(bus.LEVEL), 0);

    // 4: tick every 4th cycle
    do_reset(2, 1'b0);
    clr();
    run_btn(8, 1'b0);
    tick_per = 4;
    clr();
    run_btn(80, 1'b1);
    chk("t4_press_edge", press_at, 64);
    chk("t4_press_cnt", press_n, 1);
    tick_per = 1;
    do_reset(2, 1'b0);
    clr();
    run_btn(8, 1'b0);
    tick_per = 4;
    clr();
    run_btn(40, 1'b1);
    run_btn(20, 1'b0);
    chk("t4_short_no_press", press_n, 0);
    chk("t4_short_no_rel", rel_n, 0);
    chk("t4_short_level", int'(bus.LEVEL), 0);
    tick_per = 1;

    // 6: reset while count is 10 in RISE_WAIT
    do_reset(2, 1'b0);
    clr();
    run_btn(5, 1'b0);
    clr();
    run_btn(13, 1'b1);
    chk("t6_pre_rst_press", press_n, 0);
    do_reset(1, 1'b1);
    clr();
    run_btn(40, 1'b1);
    chk("t6_press_edge", press_at, 19);
    chk("t6_press_cnt", press_n, 1);

    chk("never_both_strobes", both_n, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
